// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath: loads operands, steers the
// subtract muxes from the compare flags and aborts on step overrun or bad flags.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic asel,
  output logic bsel,
  output logic aload,
  output logic bload,
  output logic out_en,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned CW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic flags_ok;
  logic limit_hit;
  logic calc_err;

  // Exactly one compare flag must be high; anything else means a broken datapath.
  assign flags_ok  = $onehot({gt, lt, eq});
  assign limit_hit = (cnt_q == CW'(MAX_ITER));
  assign calc_err  = !flags_ok || (limit_hit && !eq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (calc_err) begin
          state_d = S_ERR;
        end else if (eq) begin
          state_d = S_DONE;
        end else if (!limit_hit) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low combinationally while reset is held.
  always_comb begin
    asel   = 1'b0;
    bsel   = 1'b0;
    aload  = 1'b0;
    bload  = 1'b0;
    out_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_LOAD: begin
          asel  = 1'b1;
          bsel  = 1'b1;
          aload = 1'b1;
          bload = 1'b1;
          busy  = 1'b1;
        end
        S_CALC: begin
          busy = 1'b1;
          if (!calc_err) begin
            if (gt) aload = 1'b1;
            if (lt) bload = 1'b1;
            if (eq) out_en = 1'b1;
          end
        end
        S_DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        S_ERR: begin
          busy = 1'b1;
          done = 1'b1;
          err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
